// File: rtl/tile_game_pkg.sv
// Shared types for the tile-matching game: turn-sequencer states and the
// mode codes that the HEX display logic decodes.
package tile_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK1,
    S_PICK2,
    S_REVEAL,
    S_RESOLVE,
    S_DONE
  } state_e;

  localparam logic [1:0] MODE_MENU   = 2'd0;
  localparam logic [1:0] MODE_INGAME = 2'd1;
  localparam logic [1:0] MODE_END    = 2'd2;

  localparam int DEFAULT_COLOR_W = 4;

  function automatic logic [1:0] mode_of(input state_e s);
    case (s)
      S_IDLE:  mode_of = MODE_MENU;
      S_DONE:  mode_of = MODE_END;
      default: mode_of = MODE_INGAME;
    endcase
  endfunction

endpackage

// File: rtl/reveal_timer.sv
// Loadable down-counter that times how long a revealed pair stays face-up.
// It stops at zero; done is high whenever the count is zero.
module reveal_timer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/tile_match_controller.sv
// Turn sequencer for the tile-matching game: turns switch rises into picks,
// holds each revealed pair for a fixed window, then scores it.
module tile_match_controller
  import tile_game_pkg::*;
#(
  parameter int NUM_TILES     = 10,
  parameter int COLOR_W       = DEFAULT_COLOR_W,
  parameter int SCORE_W       = 8,
  parameter int REVEAL_CYCLES = 100_000_000
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         quit,
  input  logic [NUM_TILES-1:0]         sw,
  input  logic [NUM_TILES*COLOR_W-1:0] tile_color,
  output logic [1:0]                   mode,
  output logic [NUM_TILES-1:0]         reveal_mask,
  output logic [NUM_TILES-1:0]         matched_mask,
  output logic [COLOR_W-1:0]           color_a,
  output logic [COLOR_W-1:0]           color_b,
  output logic                         show_a,
  output logic                         show_b,
  output logic [SCORE_W-1:0]           move_count,
  output logic                         all_matched
);

  localparam int IDX_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int TIMER_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [NUM_TILES-1:0]   sw_q, rise_q;
  logic [IDX_W-1:0]       idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [COLOR_W-1:0]     color_a_q, color_a_d, color_b_q, color_b_d;
  logic [NUM_TILES-1:0]   reveal_q, reveal_d, matched_q, matched_d;
  logic                   show_a_q, show_a_d, show_b_q, show_b_d;
  logic [SCORE_W-1:0]     count_q, count_d;
  logic [1:0]             mode_q;
  logic                   all_matched_q;

  logic [NUM_TILES-1:0]   qual;
  logic [IDX_W-1:0]       pick;
  logic [COLOR_W-1:0]     color_tbl [NUM_TILES];
  logic                   timer_load, timer_done;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_TILES-1:0] v);
    lowest_set = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_TILES; i++) begin
      color_tbl[i] = tile_color[i*COLOR_W +: COLOR_W];
    end
  end

  reveal_timer #(.W(TIMER_W)) u_timer (
    .clk_i        (CLOCK_50),
    .rst_i        (reset),
    .load_i       (timer_load),
    .load_value_i (TIMER_W'(REVEAL_CYCLES - 1)),
    .done_o       (timer_done)
  );

  // NOTE: every signal gets its hold value before the case; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_a_d    = idx_a_q;
    idx_b_d    = idx_b_q;
    color_a_d  = color_a_q;
    color_b_d  = color_b_q;
    reveal_d   = reveal_q;
    matched_d  = matched_q;
    show_a_d   = show_a_q;
    show_b_d   = show_b_q;
    count_d    = count_q;
    timer_load = 1'b0;

    qual = rise_q & ~matched_q;
    if (state_q == S_PICK2) qual[idx_a_q] = 1'b0;
    pick = lowest_set(qual);

    if (quit && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      reveal_d  = '0;
      matched_d = '0;
      show_a_d  = 1'b0;
      show_b_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_PICK1;
            reveal_d  = '0;
            matched_d = '0;
            count_d   = '0;
          end
        end
        S_PICK1: begin
          if (|qual) begin
            idx_a_d        = pick;
            color_a_d      = color_tbl[pick];
            reveal_d[pick] = 1'b1;
            show_a_d       = 1'b1;
            state_d        = S_PICK2;
          end
        end
        S_PICK2: begin
          if (|qual) begin
            idx_b_d        = pick;
            color_b_d      = color_tbl[pick];
            reveal_d[pick] = 1'b1;
            show_b_d       = 1'b1;
            timer_load     = 1'b1;
            state_d        = S_REVEAL;
          end
        end
        S_REVEAL: begin
          if (timer_done) state_d = S_RESOLVE;
        end
        S_RESOLVE: begin
          if (count_q != '1) count_d = count_q + 1'b1;
          if (color_a_q == color_b_q) begin
            matched_d[idx_a_q] = 1'b1;
            matched_d[idx_b_q] = 1'b1;
          end
          reveal_d = '0;
          show_a_d = 1'b0;
          show_b_d = 1'b0;
          state_d  = (&matched_d) ? S_DONE : S_PICK1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sw_q          <= '0;
      rise_q        <= '0;
      idx_a_q       <= '0;
      idx_b_q       <= '0;
      color_a_q     <= '0;
      color_b_q     <= '0;
      reveal_q      <= '0;
      matched_q     <= '0;
      show_a_q      <= 1'b0;
      show_b_q      <= 1'b0;
      count_q       <= '0;
      mode_q        <= MODE_MENU;
      all_matched_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sw_q          <= sw;
      // Rises seen outside the pick states are dropped, never queued.
      rise_q        <= (state_q == S_PICK1 || state_q == S_PICK2) ? (sw & ~sw_q) : '0;
      idx_a_q       <= idx_a_d;
      idx_b_q       <= idx_b_d;
      color_a_q     <= color_a_d;
      color_b_q     <= color_b_d;
      reveal_q      <= reveal_d;
      matched_q     <= matched_d;
      show_a_q      <= show_a_d;
      show_b_q      <= show_b_d;
      count_q       <= count_d;
      mode_q        <= mode_of(state_d);
      all_matched_q <= (state_d == S_DONE);
    end
  end

  assign mode         = mode_q;
  assign reveal_mask  = reveal_q;
  assign matched_mask = matched_q;
  assign color_a      = color_a_q;
  assign color_b      = color_b_q;
  assign show_a       = show_a_q;
  assign show_b       = show_b_q;
  assign move_count   = count_q;
  assign all_matched  = all_matched_q;

endmodule

// File: tb/tb_tile_match_controller.sv
// Directed bench for tile_match_controller on a 4-tile board, with a
// pick-list reference model compared against the outputs every cycle.
module tb_tile_match_controller;

  localparam int NT = 4;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam int RC = 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          start, quit;
  logic [NT-1:0] sw;
  logic [NT*CW-1:0] tile_color;
  logic [1:0]    mode;
  logic [NT-1:0] reveal_mask, matched_mask;
  logic [CW-1:0] color_a, color_b;
  logic          show_a, show_b, all_matched;
  logic [SW-1:0] move_count;

  int n_checks = 0;
  int n_fail   = 0;

  tile_match_controller #(
    .NUM_TILES(NT), .COLOR_W(CW), .SCORE_W(SW), .REVEAL_CYCLES(RC)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .start        (start),
    .quit         (quit),
    .sw           (sw),
    .tile_color   (tile_color),
    .mode         (mode),
    .reveal_mask  (reveal_mask),
    .matched_mask (matched_mask),
    .color_a      (color_a),
    .color_b      (color_b),
    .show_a       (show_a),
    .show_b       (show_b),
    .move_count   (move_count),
    .all_matched  (all_matched)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a game is a list of at most two picks plus a countdown
  // of the cycles the second pick stays visible.
  int            m_mode;
  int            picks[$];
  int            window;
  int            m_moves;
  logic [NT-1:0] m_matched, m_pend, m_sw_prev;

  function automatic logic [CW-1:0] color_of(input int i);
    return tile_color[i*CW +: CW];
  endfunction

  task automatic model_reset();
    m_mode = 0; picks.delete(); window = 0; m_moves = 0;
    m_matched = '0; m_pend = '0; m_sw_prev = '0;
  endtask

  task automatic model_step();
    logic [NT-1:0] new_pend, q;
    bit found;
    new_pend  = (m_mode == 1 && picks.size() < 2) ? (sw & ~m_sw_prev) : '0;
    m_sw_prev = sw;
    if (quit && m_mode != 0) begin
      m_mode = 0; picks.delete(); window = 0; m_matched = '0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_matched = '0; m_moves = 0; picks.delete();
      end
    end else if (picks.size() < 2) begin
      q = m_pend & ~m_matched;
      if (picks.size() == 1) q[picks[0]] = 1'b0;
      found = 0;
      for (int i = 0; i < NT; i++) begin
        if (q[i] && !found) begin
          picks.push_back(i);
          found = 1;
        end
      end
      if (found && picks.size() == 2) window = RC + 1;
    end else begin
      window--;
      if (window == 0) begin
        if (m_moves < (1 << SW) - 1) m_moves++;
        if (color_of(picks[0]) == color_of(picks[1])) begin
          m_matched[picks[0]] = 1'b1;
          m_matched[picks[1]] = 1'b1;
        end
        picks.delete();
        if (m_matched == '1) m_mode = 2;
      end
    end
    m_pend = new_pend;
  endtask

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  always @(negedge CLOCK_50) begin
    logic [NT-1:0] exp_reveal;
    if (!reset) begin
      exp_reveal = '0;
      foreach (picks[k]) exp_reveal[picks[k]] = 1'b1;
      check("mdl_mode",    mode,         m_mode);
      check("mdl_reveal",  reveal_mask,  exp_reveal);
      check("mdl_matched", matched_mask, m_matched);
      check("mdl_show_a",  show_a,       picks.size() >= 1);
      check("mdl_show_b",  show_b,       picks.size() == 2);
      check("mdl_moves",   move_count,   m_moves);
      check("mdl_all",     all_matched,  m_mode == 2);
      if (picks.size() >= 1) check("mdl_color_a", color_a, color_of(picks[0]));
      if (picks.size() == 2) check("mdl_color_b", color_b, color_of(picks[1]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pick(input int i);
    sw[i] = 1'b1; tick(2);
  endtask

  task automatic mismatch_round();
    sw = '0; tick(1);
    pick(0); pick(1); tick(RC + 1);
  endtask

  initial begin
    tile_color = {4'd2, 4'd1, 4'd2, 4'd1};
    reset = 1'b1; start = 1'b0; quit = 1'b0; sw = '0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    check("rst_mode",    mode,         0);
    check("rst_reveal",  reveal_mask,  0);
    check("rst_matched", matched_mask, 0);
    check("rst_moves",   move_count,   0);
    check("rst_show",    {show_a, show_b, all_matched}, 0);

    // Match 0/2, with pick latency pinned.
    pulse_start();
    check("start_mode", mode, 1);
    sw[0] = 1'b1; tick(1);
    check("lat_reveal_early", reveal_mask, 4'b0000);
    tick(1);
    check("pick_a_reveal", reveal_mask, 4'b0001);
    check("pick_a_show",   show_a, 1);
    check("pick_a_color",  color_a, 1);
    pick(2);
    check("pick_b_reveal", reveal_mask, 4'b0101);
    check("pick_b_color",  color_b, 1);
    tick(RC);
    check("window_show_b", show_b, 1);
    tick(1);
    check("match_matched", matched_mask, 4'b0101);
    check("match_moves",   move_count, 1);
    check("match_reveal",  reveal_mask, 0);
    check("match_show_b",  show_b, 0);

    // Re-raising a matched tile is ignored.
    sw = '0; tick(1);
    pick(0);
    check("matched_ignored", {show_a, reveal_mask}, 0);

    // Pair 1/3, re-raising idx_a in between is ignored.
    pick(1);
    check("p13_color_a", color_a, 2);
    sw[1] = 1'b0; tick(1);
    pick(1);
    check("idx_a_ignored", {show_b, reveal_mask}, {1'b0, 4'b0010});
    pick(3);
    check("p13_color_b", color_b, 2);
    tick(RC + 1);
    check("done_all",   all_matched, 1);
    check("done_mode",  mode, 2);
    check("done_moves", move_count, 2);
    pulse_start();
    check("restart_mode",    mode, 1);
    check("restart_moves",   move_count, 0);
    check("restart_matched", matched_mask, 0);

    // Simultaneous rise: lowest wins, the other is discarded.
    sw = '0; tick(1);
    sw = 4'b0011; tick(2);
    check("simul_reveal", reveal_mask, 4'b0001);
    check("simul_show_b", show_b, 0);
    sw[1] = 1'b0; tick(1);
    pick(1);
    check("mm_color_b", color_b, 2);
    tick(RC + 1);
    check("mm_matched", matched_mask, 0);
    check("mm_reveal",  reveal_mask, 0);
    check("mm_moves",   move_count, 1);
    check("mm_mode",    mode, 1);
    for (int r = 0; r < 3; r++) mismatch_round();
    check("sat_moves", move_count, 3);

    // Match 0/2 again, then quit with start mid-REVEAL of 1/3.
    sw = '0; tick(1);
    pick(0); pick(2); tick(RC + 1);
    check("pre_quit_matched", matched_mask, 4'b0101);
    pick(1); pick(3); tick(2);
    quit = 1'b1; start = 1'b1; tick(1);
    quit = 1'b0; start = 1'b0;
    check("quit_mode",    mode, 0);
    check("quit_masks",   {reveal_mask, matched_mask}, 0);
    check("quit_show",    {show_a, show_b}, 0);
    check("quit_moves",   move_count, 3);
    tick(2);
    check("quit_stays_idle", mode, 0);

    // Asynchronous reset mid-REVEAL.
    pulse_start();
    sw = '0; tick(1);
    pick(0); pick(2); tick(1);
    check("pre_rst_show_b", show_b, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_mode",    mode, 0);
    check("arst_masks",   {reveal_mask, matched_mask}, 0);
    check("arst_colors",  {color_a, color_b}, 0);
    check("arst_flags",   {show_a, show_b, all_matched}, 0);
    check("arst_moves",   move_count, 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    check("post_rst_mode", mode, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
